correlator_sequencer: RTL

Drives the time-multiplexed correlator blocks. It latches each antenna sample, sweeps the correlator's read address through all `TRATE` pair slots, and generates the matching write address after the accumulator pipeline lag. It counts samples per integration block and asserts `sw` on the first pass of every block so the accumulators clear. At each block boundary it flips the bank indicator and pulses `swap_o` towards the bus side. One instance feeds a common set of correlators in parallel.

---
 rtl/correlator_sequencer_if.sv | 20 ++
 rtl/correlator_sequencer.sv | 70 +++++++
 2 files changed

// File: rtl/correlator_sequencer_if.sv
// correlator_sequencer_if: sample strobe in, correlator control and addresses out
interface correlator_sequencer_if #(
  parameter int TBITS = 4,
  parameter int CBITS = 16
);
  logic strobe;
  logic [23:0] re_i, im_i;
  logic [CBITS-1:0] count_i;
  logic en, sw, bank, swap_o, busy, overrun;
  logic [23:0] re, im;
  logic [TBITS-1:0] rd, wr;
  modport master (
    output strobe, re_i, im_i, count_i,
    input en, sw, re, im, rd, wr, bank, swap_o, busy, overrun
  );
  modport slave (
    input strobe, re_i, im_i, count_i,
    output en, sw, re, im, rd, wr, bank, swap_o, busy, overrun
  );
endinterface

// File: rtl/correlator_sequencer.sv
// correlator_sequencer: sweeps correlator pair slots per sample and sequences block clears and bank swaps
module correlator_sequencer #(
  parameter int TRATE = 12,
  parameter int TBITS = 4,
  parameter int CBITS = 16,
  parameter int LAG = 2
) (
  input logic clk_x,
  input logic rst,
  correlator_sequencer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [TBITS-1:0] RD_LAST = TBITS'(TRATE - 1);
  state_t state_q, state_d;
  logic [TBITS-1:0] rd_q, rd_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [23:0] re_q, im_q;
  logic clr_pend_q, clr_pend_d, overrun_q, bank_q;
  logic [LAG-1:0][TBITS-1:0] wp_q;
  logic [LAG:0] tag_q;
  logic run, last, accept, blk_end;
  always_comb begin
    run = state_q == RUN;
    last = run && rd_q == RD_LAST;
    accept = bus.strobe && (!run || last);
    blk_end = last && cnt_q >= bus.count_i;
    state_d = accept ? RUN : (last ? IDLE : state_q);
    rd_d = (run && !last) ? rd_q + 1'b1 : '0;
    cnt_d = last ? (blk_end ? '0 : cnt_q + 1'b1) : cnt_q;
    clr_pend_d = last ? blk_end : clr_pend_q;
  end
  always_ff @(posedge clk_x) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= '0;
      cnt_q <= '0;
      clr_pend_q <= 1'b1;
      re_q <= '0;
      im_q <= '0;
      overrun_q <= 1'b0;
      bank_q <= 1'b0;
      wp_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      clr_pend_q <= clr_pend_d;
      if (accept) begin
        re_q <= bus.re_i;
        im_q <= bus.im_i;
      end
      overrun_q <= overrun_q | (bus.strobe && run && !last);
      wp_q[0] <= run ? rd_q : wp_q[0];
      for (int i = 1; i < LAG; i++) wp_q[i] <= wp_q[i-1];
      tag_q <= {tag_q[LAG-1:0], blk_end};
      bank_q <= bank_q ^ tag_q[LAG-1];
    end
  end
  assign bus.en = run;
  assign bus.busy = run;
  assign bus.sw = run && clr_pend_q;
  assign bus.rd = rd_q;
  assign bus.wr = wp_q[LAG-1];
  assign bus.re = re_q;
  assign bus.im = im_q;
  assign bus.bank = bank_q;
  assign bus.swap_o = tag_q[LAG];
  assign bus.overrun = overrun_q;
endmodule
